// File: rtl/npu_bus_pkg.sv
// Shared definitions for the NPU host port: opcodes, slave regions, ctrl bits.
// The package also holds the master FSM encoding and the address helper.
package npu_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_ILL   = 2'b11
    } op_e;

    localparam logic [2:0] SEL_IMG    = 3'd1;
    localparam logic [2:0] SEL_CONVW  = 3'd2;
    localparam logic [2:0] SEL_FCN    = 3'd3;
    localparam logic [2:0] SEL_CTRL   = 3'd4;
    localparam logic [2:0] SEL_DONE   = 3'd5;
    localparam logic [2:0] SEL_RESULT = 3'd6;
    localparam logic [2:0] SEL_VALID  = 3'd7;

    localparam int CTRL_TRIGGER  = 0;
    localparam int CTRL_NEXT     = 1;
    localparam int CTRL_PE_CLR   = 2;
    localparam int CTRL_IMG_CLR  = 3;
    localparam int CTRL_W_CLR    = 4;
    localparam int CTRL_PACK_CLR = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_CHECK, S_GAP, S_RESP
    } state_e;

    function automatic logic [15:0] addr_of(input logic [2:0] sel);
        return {1'b0, sel, 12'h000};
    endfunction

endpackage

// File: rtl/npu_host_master.sv
// Command-driven bus master for the NPU host port: WRITE, READ and POLL
// operations with a registered bus interface and a held response stream.
module npu_host_master
    import npu_bus_pkg::*;
#(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 2,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_sel,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    input  logic [31:0] douta,
    output logic        busy
);

    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam bit               HAS_GAP   = (POLL_GAP > 0);

    state_e           state, state_nx;
    op_e              op_q;
    logic [31:0]      data_q, mask_q;
    logic [CNT_W-1:0] poll_cnt, gap_cnt;
    logic             match, poll_last, gap_last;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // rsp_data already holds the sampled douta when CHECK is reached
    assign match     = ((rsp_data ^ data_q) & mask_q) == '0;
    assign poll_last = (poll_cnt == POLL_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_WRITE:        state_nx = S_WR;
                        OP_READ, OP_POLL: state_nx = S_RD_REQ;
                        default:         state_nx = S_RESP;
                    endcase
                end
            end
            S_WR:      state_nx = S_GAP;
            S_RD_REQ:  state_nx = S_RD_WAIT;
            S_RD_WAIT: state_nx = (op_q == OP_POLL) ? S_CHECK : S_RESP;
            S_CHECK: begin
                if (match || poll_last) state_nx = S_RESP;
                else if (HAS_GAP)       state_nx = S_GAP;
                else                    state_nx = S_RD_REQ;
            end
            // a write always spends exactly one idle cycle here so ctrl pulses clear
            S_GAP: begin
                if (op_q == OP_WRITE) state_nx = S_IDLE;
                else if (gap_last)    state_nx = S_RD_REQ;
            end
            S_RESP:    if (rsp_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_WRITE;
            data_q    <= '0;
            mask_q    <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            ena       <= (state_nx == S_WR) || (state_nx == S_RD_REQ);
            wea       <= (state_nx == S_WR);
            rsp_valid <= (state_nx == S_RESP);

            if (state == S_IDLE && cmd_valid) begin
                op_q     <= op_e'(cmd_op);
                data_q   <= cmd_data;
                mask_q   <= cmd_mask;
                poll_cnt <= '0;
                addra    <= addr_of(cmd_sel);
                dina     <= cmd_data;
                rsp_err  <= (op_e'(cmd_op) == OP_ILL);
                if (op_e'(cmd_op) == OP_ILL) rsp_data <= '0;
            end

            if (state == S_RD_WAIT) rsp_data <= douta;

            if (state == S_CHECK) begin
                gap_cnt <= '0;
                if (!match) begin
                    if (poll_last) rsp_err  <= 1'b1;
                    else           poll_cnt <= poll_cnt + CNT_W'(1);
                end
            end

            if (state == S_GAP) gap_cnt <= gap_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_npu_host_master.sv
// Directed bench for npu_host_master with a one-cycle-latency slave model
// and a monitor for the ena/wea bus rules.
module tb_npu_host_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_sel;
    logic [31:0] cmd_data, cmd_mask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ena, wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    npu_host_master #(.POLL_MAX(4), .POLL_GAP(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .douta(douta), .busy(busy)
    );

    // slave model: read data appears the cycle after the request edge
    int   rd_n = 0, wr_n = 0, viol = 0, cyc = 0;
    int   base = 0, valid_at = 1000;
    int   strobe_cyc [64];
    logic prev_ena = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_ena <= ena;
        if ((ena && prev_ena) || (wea && !ena)) viol <= viol + 1;
        if (ena && wea) wr_n <= wr_n + 1;
        if (ena && !wea) begin
            if (rd_n < 64) strobe_cyc[rd_n] <= cyc;
            rd_n <= rd_n + 1;
            case (addra)
                16'h6000: douta <= 32'hDEADBEEF;
                16'h7000: douta <= (rd_n - base + 1 >= valid_at) ? 32'h1 : 32'h0;
                16'h5000: douta <= 32'(32'h100 + rd_n - base + 1);
                default:  douta <= 32'h0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [2:0] sel,
                             input logic [31:0] data, input logic [31:0] mask);
        cmd_op = op; cmd_sel = sel; cmd_data = data; cmd_mask = mask;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc);
        for (int i = 0; i < max_cyc && !rsp_valid; i++) @(negedge clk);
        check("rsp_arrives", {31'b0, rsp_valid}, 32'h1);
    endtask

    task automatic ack(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'h0);
        check({tag, "_ready"}, {31'b0, cmd_ready}, 32'h1);
    endtask

    task automatic do_write_ctrl(input string tag);
        int wbase;
        wbase = wr_n;
        drive_cmd(2'b00, 3'd4, 32'h1, 32'h0);
        check({tag, "_ena"}, {31'b0, ena}, 32'h1);
        check({tag, "_wea"}, {31'b0, wea}, 32'h1);
        check({tag, "_addra"}, {16'b0, addra}, 32'h4000);
        check({tag, "_dina"}, dina, 32'h1);
        check({tag, "_busy_ready"}, {30'b0, busy, cmd_ready}, 32'h2);
        @(negedge clk);
        check({tag, "_gap_ena"}, {30'b0, ena, wea}, 32'h0);
        check({tag, "_gap_ready"}, {31'b0, cmd_ready}, 32'h0);
        @(negedge clk);
        check({tag, "_idle"}, {30'b0, busy, cmd_ready}, 32'h1);
        check({tag, "_one_write"}, 32'(wr_n - wbase), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0;
        cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, cmd_ready}, 32'h1);
        check("rst_bus", {30'b0, ena, wea}, 32'h0);
        check("rst_addra", {16'b0, addra}, 32'h0);
        check("rst_dina", dina, 32'h0);
        check("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: ctrl write yields a single ena/wea pulse
        do_write_ctrl("t1");

        // 2: read with fixed latency, response held under backpressure
        base = rd_n;
        drive_cmd(2'b01, 3'd6, 32'h0, 32'h0);
        check("t2_ena", {30'b0, ena, wea}, 32'h2);
        check("t2_addra", {16'b0, addra}, 32'h6000);
        @(negedge clk);
        check("t2_wait", {30'b0, ena, rsp_valid}, 32'h0);
        @(negedge clk);
        check("t2_valid", {31'b0, rsp_valid}, 32'h1);
        check("t2_err", {31'b0, rsp_err}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data", rsp_data, 32'hDEADBEEF);
            check("t2_hold_valid", {31'b0, rsp_valid}, 32'h1);
            @(negedge clk);
        end
        ack("t2");
        check("t2_reads", 32'(rd_n - base), 32'h1);

        // 3: poll matches on the third read; strobes 5 cycles apart
        base = rd_n; valid_at = 3;
        drive_cmd(2'b10, 3'd7, 32'h1, 32'h1);
        wait_rsp(100);
        check("t3_err", {31'b0, rsp_err}, 32'h0);
        check("t3_data", rsp_data, 32'h1);
        check("t3_reads", 32'(rd_n - base), 32'h3);
        check("t3_space1", 32'(strobe_cyc[base+1] - strobe_cyc[base]), 32'h5);
        check("t3_space2", 32'(strobe_cyc[base+2] - strobe_cyc[base+1]), 32'h5);
        ack("t3");

        // 4: poll never matches; times out after POLL_MAX reads
        base = rd_n;
        drive_cmd(2'b10, 3'd5, 32'hAA, 32'hFF);
        wait_rsp(200);
        check("t4_err", {31'b0, rsp_err}, 32'h1);
        check("t4_data", rsp_data, 32'h104);
        check("t4_reads", 32'(rd_n - base), 32'h4);
        ack("t4");

        // 5: illegal op responds at once with no bus activity
        base = rd_n;
        begin
            int wb;
            wb = wr_n;
            drive_cmd(2'b11, 3'd4, 32'h55, 32'h0);
            check("t5_valid", {31'b0, rsp_valid}, 32'h1);
            check("t5_err", {31'b0, rsp_err}, 32'h1);
            check("t5_data", rsp_data, 32'h0);
            check("t5_ena", {31'b0, ena}, 32'h0);
            ack("t5");
            check("t5_no_bus", 32'(rd_n - base + wr_n - wb), 32'h0);
        end

        // 6a: reset during the second read request of a poll
        base = rd_n; valid_at = 1000;
        drive_cmd(2'b10, 3'd7, 32'h1, 32'h1);
        repeat (5) @(negedge clk);
        check("t6_second_req", {31'b0, ena}, 32'h1);
        check("t6_reads_before", 32'(rd_n - base), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_ena_async", {31'b0, ena}, 32'h0);
        check("t6_idle_async", {30'b0, busy, cmd_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 6b: reset while a response is pending
        drive_cmd(2'b11, 3'd0, 32'h0, 32'h0);
        check("t6_resp_up", {31'b0, rsp_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_resp_drop", {30'b0, rsp_valid, rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after", {31'b0, cmd_ready}, 32'h1);
        do_write_ctrl("t6w");

        check("bus_rules", 32'(viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
